pll_reset_sequencer: RTL

//  Consumer/controller end of the system PLL's rst/locked interface. Drives the PLL reset and monitors
//  its locked output. Runs on the 50 MHz reference clock, which is valid even when the PLL is unlocked.

---
 rtl/pll_reset_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the system PLL: pulses the PLL reset, waits for a stable lock,
// then releases the core and peripheral resets in order, retrying a bounded number of times.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 50,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int STAGE_GAP_CYCLES    = 16,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked_async,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       periph_reset,
  output logic       ready,
  output logic [1:0] retry_count,
  output logic       lock_fail,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_REL_SYS   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [1:0]       MAX_R        = 2'(MAX_RETRIES);

  logic             sync1, lk;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d, retry_inc;

  // Two-flop synchroniser; every FSM decision looks at lk only.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked_async;
      lk    <= sync1;
    end
  end

  assign retry_inc = retry_q + 2'd1;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes priority over the timeout.
        if (lk) begin
          state_d = S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == MAX_R) ? S_FAIL : S_PLL_RST;
        end
      end
      S_STABLE: begin
        if (!lk) state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_REL_SYS;
      end
      S_REL_SYS: begin
        if (!lk) state_d = S_PLL_RST;
        else if (cnt_q == GAP_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lk) state_d = S_PLL_RST;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_PLL_RST;
      end
    endcase

    if (state_d == S_RUN && state_q != S_RUN) retry_d = 2'd0;

    // The counter restarts on every state change and free-runs otherwise.
    if (state_d != state_q) cnt_d = '0;
    else cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_PLL_RST;
      cnt_q   <= '0;
      retry_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as state_q.
  always_ff @(posedge refclk) begin
    if (rst) begin
      pll_rst      <= 1'b1;
      sys_reset    <= 1'b1;
      periph_reset <= 1'b1;
      ready        <= 1'b0;
      lock_fail    <= 1'b0;
    end else begin
      pll_rst      <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
      sys_reset    <= !((state_d == S_REL_SYS) || (state_d == S_RUN));
      periph_reset <= (state_d != S_RUN);
      ready        <= (state_d == S_RUN);
      lock_fail    <= (state_d == S_FAIL);
    end
  end

  assign retry_count = retry_q;
  assign state_dbg   = state_q;

endmodule
